// File: rtl/kronecker_pkg.sv
// Shared constants, share-slice helpers and Boolean-sharing types for the
// d=2 Kronecker delta path of the multiplicative-masking S-box.
package kronecker_pkg;

    localparam int unsigned KD_LAT    = 3;
    localparam int unsigned KD_SHARES = 3;
    localparam int unsigned KD_WIDTH  = 8;
    localparam int unsigned KD_BUS_W  = KD_SHARES * KD_WIDTH;
    localparam int unsigned KD_PRNG_W = 16;

    typedef logic [KD_WIDTH-1:0] kd_share_t;

    // 3-share Boolean-masked byte; s0 occupies the least significant byte.
    typedef struct packed {
        kd_share_t s2;
        kd_share_t s1;
        kd_share_t s0;
    } kd_byte3_t;

    // 3-share Boolean-masked bit; b0 is bit 0.
    typedef struct packed {
        logic b2;
        logic b1;
        logic b0;
    } kd_bit3_t;

    // Lowest bus bit of share idx.
    function automatic int unsigned share_lo(input int unsigned idx);
        return idx * KD_WIDTH;
    endfunction

    // Highest bus bit of share idx.
    function automatic int unsigned share_hi(input int unsigned idx);
        return share_lo(idx) + KD_WIDTH - 1;
    endfunction

    // Flip bit 0 of one share by the matching delta share; upper bits untouched.
    function automatic kd_share_t fix_share(input kd_share_t s, input logic d);
        return {s[KD_WIDTH-1:1], s[0] ^ d};
    endfunction

endpackage

// File: rtl/kronecker_zero_fix_d2_if.sv
// Beat bus between the Kronecker delta unit, the zero-fix stage and its consumer.
interface kronecker_zero_fix_d2_if;
    import kronecker_pkg::*;

    logic                   in_valid;
    kd_byte3_t              shared_inp;
    kd_bit3_t               delta_shares;
    logic [KD_PRNG_W-1:0]   PRNG;
    logic                   out_valid;
    kd_byte3_t              out_shares;
    kd_bit3_t               out_delta;

    // Upstream/environment side: drives beats, delta and randomness.
    modport master (
        output in_valid,
        output shared_inp,
        output delta_shares,
        output PRNG,
        input  out_valid,
        input  out_shares,
        input  out_delta
    );

    // Zero-fix stage side.
    modport slave (
        input  in_valid,
        input  shared_inp,
        input  delta_shares,
        input  PRNG,
        output out_valid,
        output out_shares,
        output out_delta
    );
endinterface

// File: rtl/share_delay_line.sv
// Generic DEPTH x W shift register with async active-low reset; q is stage DEPTH.
module share_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift one stage per cycle; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/kronecker_zero_fix_d2.sv
// Zero-correction stage after the d=2 Kronecker delta unit: delays the masked
// byte to meet delta(X) and forces bit 0 so the unmasked result is never zero.
// Optional output share refresh is enabled by defining ZF_REFRESH_EN.
module kronecker_zero_fix_d2
    import kronecker_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    kronecker_zero_fix_d2_if.slave bus
);

    kd_byte3_t  data_lat;
    logic [0:0] valid_lat;
    kd_byte3_t  corr_c;

    // Data pipe: stage KD_LAT lines up with delta_shares of the same beat.
    share_delay_line #(
        .DEPTH (KD_LAT),
        .W     (KD_BUS_W)
    ) u_data_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.shared_inp),
        .q     (data_lat)
    );

    // Valid pipe running in parallel with the data pipe.
    share_delay_line #(
        .DEPTH (KD_LAT),
        .W     (1)
    ) u_valid_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.in_valid),
        .q     (valid_lat)
    );

`ifdef ZF_REFRESH_EN
    kd_share_t r0_c;
    kd_share_t r1_c;
    kd_share_t r2_c;

    // Refresh masks; the third is formed from randomness only.
    assign r0_c = bus.PRNG[KD_WIDTH-1:0];
    assign r1_c = bus.PRNG[KD_PRNG_W-1:KD_WIDTH];
    assign r2_c = r0_c ^ r1_c;
`endif

    // Per-share bit-0 correction; each share only sees its own delta share.
    always_comb begin
        corr_c    = data_lat;
        corr_c.s0 = fix_share(data_lat.s0, bus.delta_shares.b0);
        corr_c.s1 = fix_share(data_lat.s1, bus.delta_shares.b1);
        corr_c.s2 = fix_share(data_lat.s2, bus.delta_shares.b2);
`ifdef ZF_REFRESH_EN
        corr_c.s0 = corr_c.s0 ^ r0_c;
        corr_c.s1 = corr_c.s1 ^ r1_c;
        corr_c.s2 = corr_c.s2 ^ r2_c;
`endif
    end

    // Output register: loads only for a valid beat, otherwise holds data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_shares <= '0;
            bus.out_delta  <= '0;
        end else begin
            bus.out_valid <= valid_lat[0];
            if (valid_lat[0]) begin
                bus.out_shares <= corr_c;
                bus.out_delta  <= bus.delta_shares;
            end
        end
    end

endmodule

// File: tb/tb_kronecker_zero_fix_d2.sv
// Bench for kronecker_zero_fix_d2: plays the Kronecker unit's role by supplying a
// random 3-share delta(X) three cycles after each beat, and checks the outputs
// against share-level expectations and the unmasked X | (X==0) result.
module tb_kronecker_zero_fix_d2;
    import kronecker_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    kronecker_zero_fix_d2_if bus ();

    kronecker_zero_fix_d2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit          hv [0:4095];
    logic [23:0] hs [0:4095];

    logic        exp_valid;
    logic [23:0] exp_shares;
    logic [2:0]  exp_delta;
    logic [7:0]  exp_x;

    bit          zero_delta_mask;
    bit          force_prng;
    logic [15:0] prng_val;

    function automatic logic [7:0] unmask(input logic [23:0] s);
        return s[7:0] ^ s[15:8] ^ s[23:16];
    endfunction

    function automatic logic [23:0] mask(input logic [7:0] x);
        logic [7:0] s0;
        logic [7:0] s1;
        s0 = 8'($urandom);
        s1 = 8'($urandom);
        return {x ^ s0 ^ s1, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive a beat plus the delta for the beat three cycles earlier,
    // then check the registered outputs after the edge.
    task automatic step(input bit v, input logic [23:0] sh);
        logic [7:0]  x;
        logic [2:0]  d;
        logic [15:0] r;
        int          b;
        @(negedge clk);
        bus.in_valid   = v;
        bus.shared_inp = sh;
        hv[cyc] = v;
        hs[cyc] = sh;
        r = force_prng ? prng_val : 16'($urandom);
        b = cyc - 3;
        if (b >= 0 && hv[b]) begin
            x = unmask(hs[b]);
            d[1:0] = zero_delta_mask ? 2'b00 : 2'($urandom);
            d[2]   = d[0] ^ d[1] ^ (x == 8'h00);
            exp_valid  = 1'b1;
            exp_x      = x;
            exp_delta  = d;
            exp_shares = hs[b] ^ {7'b0, d[2], 7'b0, d[1], 7'b0, d[0]};
`ifdef ZF_REFRESH_EN
            exp_shares = exp_shares ^ {r[7:0] ^ r[15:8], r[15:8], r[7:0]};
`endif
        end else begin
            exp_valid = 1'b0;
            d = 3'($urandom);
        end
        bus.delta_shares = d;
        bus.PRNG         = r;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("out_shares", 32'(bus.out_shares), 32'(exp_shares));
        chk("out_delta", 32'(bus.out_delta), 32'(exp_delta));
        if (exp_valid) begin
            chk("unmasked_out", 32'(unmask(bus.out_shares)),
                32'(exp_x | {7'b0, exp_x == 8'h00}));
            chk("unmasked_delta", 32'(^bus.out_delta), 32'(exp_x == 8'h00));
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'($urandom));
    endtask

    // One-cycle async reset mid-stream; all in-flight beats are forgotten.
    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_valid  = 1'b0;
        exp_shares = '0;
        exp_delta  = '0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_shares", 32'(bus.out_shares), 32'd0);
        chk("rst_out_delta", 32'(bus.out_delta), 32'd0);
        for (int i = 0; i < 4096; i++) hv[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.shared_inp   = '0;
        bus.delta_shares = '0;
        bus.PRNG         = '0;
        zero_delta_mask  = 1'b0;
        force_prng       = 1'b0;
        prng_val         = '0;
        exp_valid        = 1'b0;
        exp_shares       = '0;
        exp_delta        = '0;
        exp_x            = '0;
        for (int i = 0; i < 4096; i++) hv[i] = 1'b0;

        // Reset state
        #2;
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_out_shares", 32'(bus.out_shares), 32'd0);
        chk("init_out_delta", 32'(bus.out_delta), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: X=0x00 single beat
        step(1'b1, 24'h993CA5);
        idle(5);

        // 2: X=0x5A, all-zero delta shares -> shares pass bit-identical
        zero_delta_mask = 1'b1;
        step(1'b1, 24'h692211);
        idle(3);
`ifndef ZF_REFRESH_EN
        chk("t2_identity", 32'(bus.out_shares), 32'h00692211);
`endif
        zero_delta_mask = 1'b0;
        idle(1);

        // 3: every X back-to-back with random shares
        for (int x = 0; x < 256; x++) step(1'b1, mask(8'(x)));
        idle(4);

        // 4: reset drops an in-flight beat; next beat is clean
        step(1'b1, mask(8'h00));
        step(1'b0, 24'($urandom));
        do_reset();
        step(1'b1, mask(8'h3E));
        idle(4);

        // 5: valid pattern 1,0,1 with a hold across the gap
        step(1'b1, mask(8'h00));
        step(1'b0, 24'($urandom));
        step(1'b1, mask(8'h07));
        idle(4);

`ifdef ZF_REFRESH_EN
        // 6: fixed refresh randomness on X=0x00
        force_prng = 1'b1;
        prng_val   = 16'hC35A;
        step(1'b1, 24'h993CA5);
        idle(3);
        force_prng = 1'b0;
        idle(1);
`endif

        // Random mix of bubbles and beats, biased toward X=0
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3, 0) == 0) step(1'b0, 24'($urandom));
            else step(1'b1, mask(($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom)));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
